// File: rtl/lag_measure_multi_if.sv
// Bus bundle for lag_measure_multi: measurement controls in, per-channel results out.
interface lag_measure_multi_if #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CNT_W    = 20
);
    logic                      start;
    logic [CHANNELS-1:0]       sensor_trigger;
    logic                      clear_stats;
    logic [CHANNELS*CNT_W-1:0] current;
    logic [CHANNELS*CNT_W-1:0] minimum;
    logic [CHANNELS*CNT_W-1:0] maximum;
    logic [CHANNELS*CNT_W-1:0] average;
    logic [CHANNELS-1:0]       valid;
    logic [CHANNELS-1:0]       avg_ready;
    logic                      busy;
    logic [CHANNELS-1:0]       timed_out;

    // Controller side: issues start/trigger/clear and consumes results.
    modport master (
        output start, sensor_trigger, clear_stats,
        input  current, minimum, maximum, average, valid, avg_ready, busy, timed_out
    );

    // Measurement block side.
    modport slave (
        input  start, sensor_trigger, clear_stats,
        output current, minimum, maximum, average, valid, avg_ready, busy, timed_out
    );
endinterface

// File: rtl/lag_measure_multi.sv
// Multi-channel video-to-sensor lag measurement: one shared cycle counter started by
// the start pulse, per-channel latency capture plus min/max/windowed-average stats.
// Optional feature: define LAG_TIMEOUT_EN to make armed channels give up when the
// counter reaches TIMEOUT (timed_out pulse, current forced to all ones).
module lag_measure_multi #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CNT_W    = 20,
    parameter int unsigned AVG_LOG2 = 4,
    parameter int unsigned TIMEOUT  = 1000000
) (
    input  logic              clock,
    input  logic              reset,
    lag_measure_multi_if.slave bus
);

    localparam int unsigned          ACC_W    = CNT_W + AVG_LOG2;
    localparam logic [CNT_W-1:0]     CNT_MAX  = '1;
    localparam logic [AVG_LOG2-1:0]  CNT_LAST = '1;
`ifdef LAG_TIMEOUT_EN
    localparam bit                   TIMEOUT_EN = 1'b1;
`else
    localparam bit                   TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_e;

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               counter_q, counter_d;
    logic [CHANNELS-1:0]            armed_q, armed_d;
    logic [CHANNELS-1:0][CNT_W-1:0] current_q, current_d;
    logic [CHANNELS-1:0][CNT_W-1:0] minimum_q, minimum_d;
    logic [CHANNELS-1:0][CNT_W-1:0] maximum_q, maximum_d;
    logic [CHANNELS-1:0][CNT_W-1:0] average_q, average_d;
    logic [CHANNELS-1:0][ACC_W-1:0] acc_q, acc_d;
    logic [CHANNELS-1:0][AVG_LOG2-1:0] count_q, count_d;
    logic [CHANNELS-1:0]            valid_q, valid_d;
    logic [CHANNELS-1:0]            avg_ready_q, avg_ready_d;
    logic [CHANNELS-1:0]            timed_out_q, timed_out_d;
    logic                           busy_q, busy_d;

    logic [CHANNELS-1:0][ACC_W-1:0] sum_c;
    logic                           timeout_hit_c;

    // Running window sum including the sample currently held in the counter.
    always_comb begin
        for (int n = 0; n < CHANNELS; n++) begin
            sum_c[n] = acc_q[n] + ACC_W'(counter_q);
        end
    end

    // Timeout fires only while measuring and only in the timeout-enabled build.
    always_comb begin
        timeout_hit_c = TIMEOUT_EN && (state_q == ST_MEASURE) && (32'(counter_q) == 32'(TIMEOUT));
    end

    // Next-state: start/restart, per-channel capture or timeout, stats and clear.
    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        armed_d     = armed_q;
        current_d   = current_q;
        minimum_d   = minimum_q;
        maximum_d   = maximum_q;
        average_d   = average_q;
        acc_d       = acc_q;
        count_d     = count_q;
        valid_d     = '0;
        avg_ready_d = '0;
        timed_out_d = '0;

        if (bus.start) begin
            // Restart wins over any trigger seen in the same cycle.
            state_d   = ST_MEASURE;
            counter_d = CNT_W'(1);
            armed_d   = '1;
        end else if (state_q == ST_MEASURE) begin
            if (counter_q != CNT_MAX) begin
                counter_d = counter_q + CNT_W'(1);
            end
            for (int n = 0; n < CHANNELS; n++) begin
                if (armed_q[n] && bus.sensor_trigger[n]) begin
                    current_d[n] = counter_q;
                    valid_d[n]   = 1'b1;
                    armed_d[n]   = 1'b0;
                    if (counter_q < minimum_q[n]) begin
                        minimum_d[n] = counter_q;
                    end
                    if (counter_q > maximum_q[n]) begin
                        maximum_d[n] = counter_q;
                    end
                    if (count_q[n] == CNT_LAST) begin
                        average_d[n]   = CNT_W'(sum_c[n] >> AVG_LOG2);
                        acc_d[n]       = '0;
                        count_d[n]     = '0;
                        avg_ready_d[n] = 1'b1;
                    end else begin
                        acc_d[n]   = sum_c[n];
                        count_d[n] = count_q[n] + AVG_LOG2'(1);
                    end
                end else if (armed_q[n] && timeout_hit_c) begin
                    // Timed-out channels report all ones and leave stats alone.
                    current_d[n]   = CNT_MAX;
                    timed_out_d[n] = 1'b1;
                    armed_d[n]     = 1'b0;
                end
            end
            if (armed_d == '0) begin
                state_d = ST_IDLE;
            end
        end

        // Clearing stats overrides any stat update from a coincident trigger.
        if (bus.clear_stats) begin
            minimum_d   = '1;
            maximum_d   = '0;
            average_d   = '0;
            acc_d       = '0;
            count_d     = '0;
            avg_ready_d = '0;
        end

        busy_d = |armed_d;
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            counter_q   <= '0;
            armed_q     <= '0;
            current_q   <= '0;
            minimum_q   <= '1;
            maximum_q   <= '0;
            average_q   <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            avg_ready_q <= '0;
            timed_out_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            armed_q     <= armed_d;
            current_q   <= current_d;
            minimum_q   <= minimum_d;
            maximum_q   <= maximum_d;
            average_q   <= average_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            avg_ready_q <= avg_ready_d;
            timed_out_q <= timed_out_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.current   = current_q;
    assign bus.minimum   = minimum_q;
    assign bus.maximum   = maximum_q;
    assign bus.average   = average_q;
    assign bus.valid     = valid_q;
    assign bus.avg_ready = avg_ready_q;
    assign bus.timed_out = timed_out_q;
    assign bus.busy      = busy_q;

endmodule
